// File: rtl/pa_pkg.sv
// Shared issue-path definitions: opcodes, formats, instruction bundle.
// Used by issue_scheduler (ISSUE_SCHED_STALL_CNT_EN) and Decode.
package pa_pkg;

  localparam int unsigned NREGS_DEF = 32;

  localparam logic [6:0] OP_ADD   = 7'd1;
  localparam logic [6:0] OP_SUB   = 7'd2;
  localparam logic [6:0] OP_MUL   = 7'd3;
  localparam logic [6:0] OP_LOAD  = 7'd4;
  localparam logic [6:0] OP_STORE = 7'd5;
  localparam logic [6:0] OP_BR_LO = 7'd8;
  localparam logic [6:0] OP_BR_HI = 7'd11;

  localparam logic FMT_REG_IMM = 1'b1;
  localparam logic FMT_REG_REG = 1'b0;

  typedef struct packed {
    logic        is_branch;
    logic        fmt;
    logic [6:0]  opcode;
    logic [4:0]  prim;
    logic [15:0] sec;
  } instr_t;

endpackage

// File: rtl/operand_classifier.sv
// Maps branch flag, format and opcode to register read/write use.
// Purely combinational; shared with Decode.
module operand_classifier
  import pa_pkg::*;
(
  input  logic       is_branch,
  input  logic       fmt,
  input  logic [6:0] opcode,
  output logic       p_read,
  output logic       p_write,
  output logic       s_read
);

  logic br_op;
  logic alu_op;
  logic mem_op;

  assign br_op  = (opcode >= OP_BR_LO) && (opcode <= OP_BR_HI);
  assign alu_op = (opcode >= OP_ADD) && (opcode <= OP_MUL);
  assign mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

  always_comb begin
    p_read  = 1'b0;
    p_write = 1'b0;
    s_read  = 1'b0;
    unique case (1'b1)
      is_branch: begin
        p_read = br_op;
        s_read = br_op;
      end
      !is_branch: begin
        p_read  = alu_op;
        p_write = alu_op || mem_op;
        s_read  = alu_op || mem_op;
      end
    endcase
    unique case (fmt)
      FMT_REG_IMM: s_read = 1'b0;
      FMT_REG_REG: s_read = s_read;
    endcase
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue stage with a RAW scoreboard enforcing LATENCY spacing.
// ISSUE_SCHED_STALL_CNT_EN adds a saturating stall counter output.
module issue_scheduler
  import pa_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned NREGS   = NREGS_DEF
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic        isBranch_i,
  input  logic        instructionFormat_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  primOperand_i,
  input  logic [15:0] secOperand_i,
  output logic        enable_o,
  output logic        isBranch_o,
  output logic        instructionFormat_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  primOperand_o,
  output logic [15:0] secOperand_o
`ifdef ISSUE_SCHED_STALL_CNT_EN
  ,
  output logic [31:0] stallCount_o
`endif
);

  localparam int unsigned CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic {
    ST_EMPTY,
    ST_HELD
  } hold_st_e;

  hold_st_e      state_q;
  hold_st_e      state_d;
  instr_t        entry_q;
  instr_t        in_instr;
  logic [CW-1:0] cnt_q [NREGS];
  logic          p_read;
  logic          p_write;
  logic          s_read;
  logic          hazard;
  logic          issue;
  logic          load_entry;
  logic [4:0]    sec_idx;

  assign in_instr = {isBranch_i, instructionFormat_i,
                     opcode_i, primOperand_i, secOperand_i};

  operand_classifier u_cls (
    .is_branch (entry_q.is_branch),
    .fmt       (entry_q.fmt),
    .opcode    (entry_q.opcode),
    .p_read    (p_read),
    .p_write   (p_write),
    .s_read    (s_read)
  );

  assign sec_idx = entry_q.sec[4:0];
  assign hazard  = (p_read && (cnt_q[entry_q.prim] != '0))
                || (s_read && (cnt_q[sec_idx] != '0));
  assign ready_o = (state_q == ST_EMPTY) || !hazard;

  always_comb begin
    state_d    = state_q;
    load_entry = 1'b0;
    issue      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (valid_i) begin
            state_d    = ST_HELD;
            load_entry = 1'b1;
          end
        end
        ST_HELD: begin
          if (!hazard) begin
            issue = 1'b1;
            if (valid_i) load_entry = 1'b1;
            else state_d = ST_EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_entry) entry_q <= in_instr;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      enable_o            <= 1'b0;
      isBranch_o          <= 1'b0;
      instructionFormat_o <= 1'b0;
      opcode_o            <= '0;
      primOperand_o       <= '0;
      secOperand_o        <= '0;
    end else begin
      enable_o <= issue;
      if (issue) begin
        isBranch_o          <= entry_q.is_branch;
        instructionFormat_o <= entry_q.fmt;
        opcode_o            <= entry_q.opcode;
        primOperand_o       <= entry_q.prim;
        secOperand_o        <= entry_q.sec;
      end
    end
  end

  // A load at issue overrides the same-edge decrement.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(NREGS); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (issue && p_write && (int'(entry_q.prim) == i))
          cnt_q[i] <= CNT_LOAD;
        else if (cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

`ifdef ISSUE_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_q <= '0;
    end else if ((state_q == ST_HELD) && hazard
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stallCount_o = stall_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed + random programs vs timing model.
// Stall count checks apply when ISSUE_SCHED_STALL_CNT_EN is defined.
module tb_issue_scheduler;

  localparam int L = 3;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        isBranch_i = 1'b0;
  logic        instructionFormat_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  primOperand_i = '0;
  logic [15:0] secOperand_i = '0;
  logic        ready_o;
  logic        enable_o;
  logic        isBranch_o;
  logic        instructionFormat_o;
  logic [6:0]  opcode_o;
  logic [4:0]  primOperand_o;
  logic [15:0] secOperand_o;
`ifdef ISSUE_SCHED_STALL_CNT_EN
  logic [31:0] stallCount_o;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clock_i = ~clock_i;

  issue_scheduler #(.LATENCY(L)) dut (
    .clock_i             (clock_i),
    .reset_ni            (reset_ni),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .flush_i             (flush_i),
    .isBranch_i          (isBranch_i),
    .instructionFormat_i (instructionFormat_i),
    .opcode_i            (opcode_i),
    .primOperand_i       (primOperand_i),
    .secOperand_i        (secOperand_i),
    .enable_o            (enable_o),
    .isBranch_o          (isBranch_o),
    .instructionFormat_o (instructionFormat_o),
    .opcode_o            (opcode_o),
    .primOperand_o       (primOperand_o),
    .secOperand_o        (secOperand_o)
`ifdef ISSUE_SCHED_STALL_CNT_EN
    ,
    .stallCount_o        (stallCount_o)
`endif
  );

  typedef struct {
    logic        isb;
    logic        fmt;
    logic [6:0]  op;
    logic [4:0]  prim;
    logic [15:0] sec;
    int          gap;
  } ins_t;

  ins_t prog[$];

  function automatic ins_t mk(input logic b, input logic f,
                              input logic [6:0] o,
                              input logic [4:0] p,
                              input logic [15:0] s,
                              input int g);
    ins_t x;
    x.isb  = b;
    x.fmt  = f;
    x.op   = o;
    x.prim = p;
    x.sec  = s;
    x.gap  = g;
    return x;
  endfunction

  function automatic bit is_br(input logic [6:0] o);
    return (o >= 8) && (o <= 11);
  endfunction

  function automatic bit f_pread(input ins_t x);
    return x.isb ? is_br(x.op) : (x.op >= 1 && x.op <= 3);
  endfunction

  function automatic bit f_pwrite(input ins_t x);
    return !x.isb && (x.op >= 1) && (x.op <= 5);
  endfunction

  function automatic bit f_sread(input ins_t x);
    if (x.fmt) return 1'b0;
    return x.isb ? is_br(x.op) : (x.op >= 1 && x.op <= 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic drive(input ins_t x);
    valid_i             = 1'b1;
    isBranch_i          = x.isb;
    instructionFormat_i = x.fmt;
    opcode_i            = x.op;
    primOperand_i       = x.prim;
    secOperand_i        = x.sec;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(enable_o), 0);
    chk({tag, "_br"}, 32'(isBranch_o), 0);
    chk({tag, "_fmt"}, 32'(instructionFormat_o), 0);
    chk({tag, "_op"}, 32'(opcode_o), 0);
    chk({tag, "_prim"}, 32'(primOperand_o), 0);
    chk({tag, "_sec"}, 32'(secOperand_o), 0);
    chk({tag, "_rdy"}, 32'(ready_o), 1);
`ifdef ISSUE_SCHED_STALL_CNT_EN
    chk({tag, "_stall"}, stallCount_o, 0);
`endif
  endtask

  // valid_i is offered during reset; nothing may be accepted.
  task automatic do_reset();
    reset_ni = 1'b0;
    flush_i  = 1'b0;
    drive(mk(0, 1, 7'd1, 5'd1, 16'd0, 0));
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    chk_zero("reset");
    idle();
    reset_ni = 1'b1;
  endtask

  // Model: accept = max(present, previous issue);
  // issue = max(accept+1, ready time of every read register).
  task automatic run_prog(input string tag);
    int pres[$];
    int acc[$];
    int iss[$];
    int rdy[32];
    int stalls;
    int prev_acc;
    int prev_iss;
    int last;
    int k;
    int n;
    n = prog.size();
    stalls = 0;
    prev_acc = -1;
    prev_iss = -1;
    k = 0;
    foreach (rdy[r]) rdy[r] = -100;
    for (int i = 0; i < n; i++) begin
      int p;
      int a;
      int s;
      p = (i == 0) ? prog[i].gap : prev_acc + 1 + prog[i].gap;
      a = (p > prev_iss) ? p : prev_iss;
      s = a + 1;
      if (f_pread(prog[i]) && rdy[prog[i].prim] > s)
        s = rdy[prog[i].prim];
      if (f_sread(prog[i]) && rdy[prog[i].sec[4:0]] > s)
        s = rdy[prog[i].sec[4:0]];
      if (f_pwrite(prog[i])) rdy[prog[i].prim] = s + L;
      stalls += s - a - 1;
      pres.push_back(p);
      acc.push_back(a);
      iss.push_back(s);
      prev_acc = a;
      prev_iss = s;
    end
    last = prev_iss + 2;
    do_reset();
    for (int t = 0; t <= last; t++) begin
      int hit;
      bit exp_rdy;
      if (t > 0) begin
        hit = -1;
        for (int i = 0; i < n; i++) if (iss[i] == t - 1) hit = i;
        chk({tag, "_en"}, 32'(enable_o), 32'(hit >= 0));
        if (hit >= 0) begin
          chk({tag, "_br"}, 32'(isBranch_o), 32'(prog[hit].isb));
          chk({tag, "_fmt"}, 32'(instructionFormat_o),
              32'(prog[hit].fmt));
          chk({tag, "_op"}, 32'(opcode_o), 32'(prog[hit].op));
          chk({tag, "_prim"}, 32'(primOperand_o),
              32'(prog[hit].prim));
          chk({tag, "_sec"}, 32'(secOperand_o), 32'(prog[hit].sec));
        end
      end
      exp_rdy = 1'b1;
      for (int i = 0; i < n; i++)
        if (acc[i] < t && t < iss[i]) exp_rdy = 1'b0;
      chk({tag, "_rdy"}, 32'(ready_o), 32'(exp_rdy));
      if (k < n && pres[k] <= t) begin
        drive(prog[k]);
        if (t == acc[k]) k++;
      end else begin
        idle();
      end
      step();
    end
    idle();
    chk({tag, "_all_acc"}, 32'(k), 32'(n));
`ifdef ISSUE_SCHED_STALL_CNT_EN
    chk({tag, "_stall"}, stallCount_o, 32'(stalls));
`endif
  endtask

  task automatic flush_test();
    do_reset();
    drive(mk(0, 1, 7'd1, 5'd2, 16'd0, 0));
    step();
    drive(mk(0, 1, 7'd2, 5'd2, 16'd0, 0));
    chk("fl_rdy0", 32'(ready_o), 1);
    step();
    chk("fl_en1", 32'(enable_o), 1);
    chk("fl_op1", 32'(opcode_o), 1);
    idle();
    flush_i = 1'b1;
    chk("fl_rdy_haz", 32'(ready_o), 0);
    step();
    flush_i = 1'b0;
    chk("fl_en2", 32'(enable_o), 0);
    chk("fl_rdy_empty", 32'(ready_o), 1);
    drive(mk(0, 1, 7'd1, 5'd2, 16'd0, 0));
    step();
    idle();
    chk("fl_en3", 32'(enable_o), 0);
    chk("fl_rdy3", 32'(ready_o), 1);
    step();
    chk("fl_en4", 32'(enable_o), 1);
    chk("fl_op4", 32'(opcode_o), 1);
    drive(mk(0, 1, 7'd3, 5'd9, 16'd0, 0));
    step();
    chk("fl_en5", 32'(enable_o), 0);
    idle();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_en6", 32'(enable_o), 0);
    step();
    chk("fl_en7", 32'(enable_o), 0);
    chk("fl_op7", 32'(opcode_o), 1);
  endtask

  task automatic reset_test();
    do_reset();
    drive(mk(0, 1, 7'd1, 5'd4, 16'd0, 0));
    step();
    drive(mk(0, 1, 7'd2, 5'd4, 16'd0, 0));
    step();
    chk("rs_en1", 32'(enable_o), 1);
    idle();
    reset_ni = 1'b0;
    #1;
    chk_zero("rs_async");
    #1;
    reset_ni = 1'b1;
    drive(mk(0, 1, 7'd1, 5'd4, 16'd0, 0));
    step();
    idle();
    chk("rs_en2", 32'(enable_o), 0);
    chk("rs_rdy2", 32'(ready_o), 1);
    step();
    chk("rs_en3", 32'(enable_o), 1);
    chk("rs_op3", 32'(opcode_o), 1);
    chk("rs_prim3", 32'(primOperand_o), 4);
  endtask

  initial begin
    prog.delete();
    prog.push_back(mk(0, 1, 7'd1, 5'd1, 16'd0, 0));
    run_prog("basic");

    prog.delete();
    prog.push_back(mk(0, 1, 7'd1, 5'd2, 16'd0, 0));
    prog.push_back(mk(0, 1, 7'd1, 5'd2, 16'd0, 0));
    run_prog("raw");
`ifdef ISSUE_SCHED_STALL_CNT_EN
    chk("raw_stall2", stallCount_o, 2);
`endif

    prog.delete();
    prog.push_back(mk(0, 1, 7'd4, 5'd7, 16'd0, 0));
    prog.push_back(mk(0, 0, 7'd2, 5'd3, 16'd7, 0));
    run_prog("sec_haz");

    prog.delete();
    prog.push_back(mk(0, 1, 7'd4, 5'd7, 16'd0, 0));
    prog.push_back(mk(0, 0, 7'd2, 5'd3, 16'd8, 0));
    run_prog("sec_free");

    prog.delete();
    for (int r = 1; r <= 6; r++)
      prog.push_back(mk(0, 1, 7'd1, 5'(r), 16'd0, 0));
    run_prog("stream");

    for (int run = 0; run < 4; run++) begin
      prog.delete();
      for (int i = 0; i < 40; i++) begin
        logic [6:0] op;
        int g;
        op = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                         : 7'($urandom_range(0, 12));
        g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        prog.push_back(mk(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), op,
                          5'($urandom_range(0, 7)),
                          {11'($urandom), 5'($urandom_range(0, 7))},
                          g));
      end
      run_prog("rand");
    end

    flush_test();
    reset_test();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

endmodule
